// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one AXI4 master port between the I-cache and D-cache
// line engines; every grant becomes a single INCR burst of LINE_WORDS beats.
module cache_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_we,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] wr_data,
    input  logic [1:0]          wr_valid,
    output logic [1:0]          wr_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic [1:0]          rsp_valid,
    output logic                rsp_last,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [7:0]          m_axi_arlen,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rlast,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready
);
    localparam int                CNT_W      = $clog2(LINE_WORDS);
    localparam int                LINE_BYTES = LINE_WORDS * DATA_W / 8;
    localparam logic [ADDR_W-1:0] LINE_MASK  = ADDR_W'(LINE_BYTES - 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(LINE_WORDS - 1);
    localparam logic [7:0]        BURST_LEN  = 8'(LINE_WORDS - 1);

    typedef enum logic [2:0] {IDLE, AR, RD, AW_W, B} state_e;

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              gnt_q, gnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              arvalid_q, arvalid_d;
    logic              awvalid_q, awvalid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;

    logic              sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic              beat_last;
    logic              r_hs;
    logic              w_hs;
    logic              aw_hs;
    logic              b_hs;
    logic              beat_err;

    // Requester at the pointer wins if it asks; bit 0 of req_we can never make a write.
    always_comb begin
        sel       = req_valid[ptr_q] ? ptr_q : ~ptr_q;
        sel_we    = sel & req_we[sel];
        sel_addr  = sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        beat_last = (cnt_q == LAST_BEAT);
        r_hs      = (state_q == RD) && m_axi_rvalid;
        w_hs      = (state_q == AW_W) && !w_done_q && wr_valid[gnt_q] && m_axi_wready;
        aw_hs     = awvalid_q && m_axi_awready;
        b_hs      = (state_q == B) && m_axi_bvalid;
        beat_err  = (r_hs && ((m_axi_rresp != 2'b00) || (m_axi_rlast != beat_last))) ||
                    (b_hs && (m_axi_bresp != 2'b00));
    end

    always_comb begin
        req_ready = 2'b00;
        if ((state_q == IDLE) && (req_valid != 2'b00) && rst_n) begin
            req_ready[sel] = 1'b1;
        end
        wr_ready = 2'b00;
        if ((state_q == AW_W) && !w_done_q) begin
            wr_ready[gnt_q] = m_axi_wready;
        end
        rsp_valid = 2'b00;
        if (r_hs || b_hs) begin
            rsp_valid[gnt_q] = 1'b1;
        end
        rsp_data      = (state_q == RD) ? m_axi_rdata : '0;
        rsp_last      = (r_hs && beat_last) || b_hs;
        rsp_err       = err_q | beat_err;
        m_axi_araddr  = araddr_q;
        m_axi_arlen   = BURST_LEN;
        m_axi_arvalid = arvalid_q;
        m_axi_rready  = (state_q == RD);
        m_axi_awaddr  = awaddr_q;
        m_axi_awlen   = BURST_LEN;
        m_axi_awvalid = awvalid_q;
        m_axi_wvalid  = (state_q == AW_W) && !w_done_q && wr_valid[gnt_q];
        m_axi_wdata   = '0;
        if (state_q == AW_W) begin
            m_axi_wdata = gnt_q ? wr_data[2*DATA_W-1:DATA_W] : wr_data[DATA_W-1:0];
        end
        m_axi_wlast   = m_axi_wvalid && beat_last;
        m_axi_bready  = (state_q == B);
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        arvalid_d = arvalid_q;
        awvalid_d = awvalid_q;
        araddr_d  = araddr_q;
        awaddr_d  = awaddr_q;
        case (state_q)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    gnt_d     = sel;
                    ptr_d     = ~sel;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (sel_we) begin
                        awvalid_d = 1'b1;
                        awaddr_d  = sel_addr & ~LINE_MASK;
                        state_d   = AW_W;
                    end else begin
                        arvalid_d = 1'b1;
                        araddr_d  = sel_addr & ~LINE_MASK;
                        state_d   = AR;
                    end
                end
            end
            AR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RD;
                end
            end
            RD: begin
                // The beat counter, not rlast, decides where the burst ends.
                if (r_hs) begin
                    err_d = err_q | beat_err;
                    cnt_d = cnt_q + 1'b1;
                    if (beat_last) begin
                        state_d = IDLE;
                    end
                end
            end
            AW_W: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    cnt_d = cnt_q + 1'b1;
                    if (beat_last) begin
                        w_done_d = 1'b1;
                    end
                end
                if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && beat_last))) begin
                    state_d = B;
                end
            end
            B: begin
                if (b_hs) begin
                    err_d   = err_q | beat_err;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            gnt_q     <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            araddr_q  <= '0;
            awaddr_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            arvalid_q <= arvalid_d;
            awvalid_q <= awvalid_d;
            araddr_q  <= araddr_d;
            awaddr_q  <= awaddr_d;
        end
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: directed requests, a small AXI slave model
// and a monitor that pops expected responses whenever the DUT presents one.
`timescale 1ns/1ps
module tb_cache_mem_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LW     = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, req_we, wr_valid, wr_ready, rsp_valid;
    logic [63:0] req_addr, wr_data;
    logic [31:0] rsp_data;
    logic        rsp_last, rsp_err;
    logic [31:0] m_axi_araddr, m_axi_awaddr, m_axi_rdata, m_axi_wdata;
    logic [7:0]  m_axi_arlen, m_axi_awlen;
    logic        m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready;
    logic [1:0]  m_axi_rresp, m_axi_bresp;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_last(rsp_last), .rsp_err(rsp_err),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    typedef struct packed {
        logic        who;
        logic        is_rd;
        logic [31:0] data;
        logic        last;
        logic        err;
    } rsp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          rsp_seen = 0;
    rsp_t        exp_q[$];
    logic [31:0] ar_exp[$];
    logic [31:0] aw_exp[$];
    logic [32:0] w_exp[$];
    logic [31:0] wq1[$];
    int          gnt_log[$];
    logic [31:0] mem [0:255];

    int          ar_wait = 0;
    int          aw_wait = 0;
    int          rresp_err_beat = -1;
    int          rlast_beat = 3;
    logic [1:0]  bresp_cfg = 2'b00;
    bit          wtog = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected at %0t", name, $time);
    endtask

    // Response monitor: pops the scoreboard whenever a response beat is presented.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && (rsp_valid != 2'b00)) begin
                rsp_seen++;
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_rsp");
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_who", 64'(rsp_valid), e.who ? 64'd2 : 64'd1);
                    if (e.is_rd) check("rsp_data", 64'(rsp_data), 64'(e.data));
                    check("rsp_last", 64'(rsp_last), 64'(e.last));
                    if (e.last) check("rsp_err", 64'(rsp_err), 64'(e.err));
                end
            end
            if (rst_n && (req_ready != 2'b00)) begin
                if (req_ready == 2'b11) fail_now("double_grant");
                gnt_log.push_back(req_ready[1] ? 1 : 0);
            end
        end
    end

    // AXI slave model; shares rst_n with the DUT.
    initial begin
        bit          rd_active = 1'b0;
        logic [31:0] rd_addr = '0;
        int          rd_beat = 0;
        bit          aw_got = 1'b0;
        int          w_cnt = 0;
        bit          phase = 1'b0;
        int          idx;
        logic [32:0] we;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
        m_axi_rlast = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rd_active = 1'b0; aw_got = 1'b0; w_cnt = 0;
                m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
                m_axi_rlast = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
                m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
            end else begin
                m_axi_arready = 1'b0;
                if (m_axi_arvalid) begin
                    if (ar_wait > 0) ar_wait--; else m_axi_arready = 1'b1;
                end
                m_axi_awready = 1'b0;
                if (m_axi_awvalid) begin
                    if (aw_wait > 0) aw_wait--; else m_axi_awready = 1'b1;
                end
                phase = ~phase;
                m_axi_wready = wtog ? phase : 1'b1;
                idx = int'(rd_addr[9:2]) + rd_beat;
                m_axi_rvalid = rd_active;
                m_axi_rdata  = rd_active ? mem[idx[7:0]] : '0;
                m_axi_rlast  = rd_active && (rd_beat == rlast_beat);
                m_axi_rresp  = (rd_active && (rd_beat == rresp_err_beat)) ? 2'b10 : 2'b00;
                m_axi_bvalid = aw_got && (w_cnt == LW);
                m_axi_bresp  = m_axi_bvalid ? bresp_cfg : 2'b00;
                #1;
                if (m_axi_arvalid && m_axi_arready) begin
                    if (ar_exp.size() == 0) fail_now("ar_unexpected");
                    else check("araddr", 64'(m_axi_araddr), 64'(ar_exp.pop_front()));
                    check("arlen", 64'(m_axi_arlen), 64'd3);
                    rd_active = 1'b1; rd_addr = m_axi_araddr; rd_beat = 0;
                end else if (m_axi_rvalid && m_axi_rready) begin
                    rd_beat++;
                    if (rd_beat == LW) rd_active = 1'b0;
                end
                if (m_axi_awvalid && m_axi_awready) begin
                    if (aw_exp.size() == 0) fail_now("aw_unexpected");
                    else check("awaddr", 64'(m_axi_awaddr), 64'(aw_exp.pop_front()));
                    check("awlen", 64'(m_axi_awlen), 64'd3);
                    aw_got = 1'b1;
                end
                if (m_axi_wvalid && m_axi_wready) begin
                    if (w_exp.size() == 0) begin
                        fail_now("w_unexpected");
                    end else begin
                        we = w_exp.pop_front();
                        check("wdata", 64'(m_axi_wdata), 64'(we[31:0]));
                        check("wlast", 64'(m_axi_wlast), 64'(we[32]));
                    end
                    w_cnt++;
                end
                if (m_axi_bvalid && m_axi_bready) begin
                    aw_got = 1'b0; w_cnt = 0;
                end
            end
        end
    end

    // D-cache write-beat source.
    initial begin
        wr_valid = 2'b00;
        wr_data  = '0;
        forever begin
            @(negedge clk);
            if (wq1.size() > 0) begin
                wr_valid[1] = 1'b1;
                wr_data[63:32] = wq1[0];
            end else begin
                wr_valid[1] = 1'b0;
            end
            #1;
            if (wr_valid[1] && wr_ready[1]) void'(wq1.pop_front());
        end
    end

    task automatic request(input int who, input logic we, input logic [31:0] addr);
        int n = 0;
        @(negedge clk);
        req_valid[who] = 1'b1;
        req_we[who] = we;
        req_addr[who*32 +: 32] = addr;
        while (1) begin
            #1;
            if (req_ready[who]) break;
            n++;
            if (n > 300) begin
                fail_now("grant_timeout");
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        req_valid[who] = 1'b0;
    endtask

    task automatic exp_read(input logic who, input logic [31:0] line, input logic err);
        rsp_t e;
        ar_exp.push_back(line);
        for (int i = 0; i < LW; i++) begin
            e.who = who; e.is_rd = 1'b1; e.data = mem[line[9:2] + 8'(i)];
            e.last = (i == LW - 1); e.err = err;
            exp_q.push_back(e);
        end
    endtask

    task automatic exp_write(input logic [31:0] line, input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] d3, input logic err);
        rsp_t e;
        aw_exp.push_back(line);
        w_exp.push_back({1'b0, d0}); w_exp.push_back({1'b0, d1});
        w_exp.push_back({1'b0, d2}); w_exp.push_back({1'b1, d3});
        wq1.push_back(d0); wq1.push_back(d1); wq1.push_back(d2); wq1.push_back(d3);
        e.who = 1'b1; e.is_rd = 1'b0; e.data = '0; e.last = 1'b1; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() + ar_exp.size() + aw_exp.size() + w_exp.size() + wq1.size()) != 0 ||
               req_valid != 2'b00) begin
            @(negedge clk);
            n++;
            if (n > 300) begin
                fail_now("drain_timeout");
                exp_q.delete(); ar_exp.delete(); aw_exp.delete(); w_exp.delete(); wq1.delete();
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_gnt(input string name, input int first, input int second);
        if (gnt_log.size() < 2) begin
            fail_now(name);
        end else begin
            check(name, 64'(gnt_log[0]), 64'(first));
            check(name, 64'(gnt_log[1]), 64'(second));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hold;
        int base;
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 32'(i);
        mem[32] = 32'h2400006f;
        mem[33] = 32'h27c0006f;
        rst_n = 1'b0; req_valid = 2'b00; req_we = 2'b00; req_addr = '0;

        // 1: reset state, then an I-cache line fill at 0x84
        repeat (5) @(negedge clk);
        #1;
        check("reset_ctrl", 64'({req_ready, wr_ready, rsp_valid, rsp_last, m_axi_arvalid, m_axi_rready,
                                 m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready}), 64'd0);
        check("reset_addr", {m_axi_araddr, m_axi_awaddr}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_read(1'b0, 32'h80, 1'b0);
        request(0, 1'b0, 32'h84);
        wait_done();

        // 3: D-cache writes; toggling wready, then AW arriving after all W beats
        wtog = 1'b1;
        exp_write(32'h200, 32'h11, 32'h22, 32'h33, 32'h44, 1'b0);
        request(1, 1'b1, 32'h204);
        wait_done();
        wtog = 1'b0;
        aw_wait = 8;
        exp_write(32'h200, 32'hA1, 32'hB2, 32'hC3, 32'hD4, 1'b0);
        request(1, 1'b1, 32'h208);
        wait_done();

        // 2: simultaneous requests, pointer 0 then pointer 1
        gnt_log.delete();
        exp_read(1'b0, 32'h40, 1'b0);
        exp_read(1'b1, 32'h1C0, 1'b0);
        fork
            request(0, 1'b0, 32'h40);
            request(1, 1'b0, 32'h1C4);
        join
        wait_done();
        check_gnt("gnt_order_ptr0", 0, 1);
        exp_read(1'b0, 32'h10, 1'b0);
        request(0, 1'b0, 32'h1C);
        wait_done();
        gnt_log.delete();
        exp_read(1'b1, 32'h30, 1'b0);
        exp_read(1'b0, 32'h20, 1'b0);
        fork
            request(0, 1'b0, 32'h20);
            request(1, 1'b0, 32'h30);
        join
        wait_done();
        check_gnt("gnt_order_ptr1", 1, 0);

        // 4: arready stalled while the D-cache waits
        gnt_log.delete();
        ar_wait = 10;
        exp_read(1'b0, 32'h100, 1'b0);
        exp_read(1'b1, 32'h300, 1'b0);
        request(0, 1'b0, 32'h10C);
        fork
            request(1, 1'b0, 32'h300);
        join_none
        base = rsp_seen;
        hold = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            #1;
            if (!(m_axi_arvalid && !m_axi_arready && m_axi_araddr == 32'h100)) hold = 1'b0;
        end
        check("ar_stall_hold", 64'(hold), 64'd1);
        check("no_grant_during_stall", 64'(gnt_log.size()), 64'd1);
        check("no_rsp_during_stall", 64'(rsp_seen), 64'(base));
        wait_done();
        check_gnt("gnt_after_stall", 0, 1);

        // 5: error reporting
        bresp_cfg = 2'b10;
        exp_write(32'h280, 32'h1, 32'h2, 32'h3, 32'h4, 1'b1);
        request(1, 1'b1, 32'h280);
        wait_done();
        bresp_cfg = 2'b00;
        rresp_err_beat = 1;
        exp_read(1'b0, 32'h50, 1'b1);
        request(0, 1'b0, 32'h58);
        wait_done();
        rresp_err_beat = -1;
        #1;
        check("err_held_idle", 64'(rsp_err), 64'd1);
        exp_read(1'b0, 32'h60, 1'b0);
        request(0, 1'b0, 32'h60);
        #1;
        check("err_clear_on_grant", 64'(rsp_err), 64'd0);
        wait_done();
        rlast_beat = 2;
        exp_read(1'b1, 32'h70, 1'b1);
        request(1, 1'b0, 32'h74);
        wait_done();
        rlast_beat = 3;

        // 6: reset after two of four read beats
        ar_exp.push_back(32'h180);
        begin
            rsp_t e;
            e.who = 1'b0; e.is_rd = 1'b1; e.last = 1'b0; e.err = 1'b0;
            e.data = mem[96]; exp_q.push_back(e);
            e.data = mem[97]; exp_q.push_back(e);
        end
        base = rsp_seen;
        request(0, 1'b0, 32'h188);
        n = 0;
        while (rsp_seen < base + 2 && n < 100) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (n >= 100) fail_now("mid_burst_timeout");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctrl", 64'({req_ready, wr_ready, rsp_valid, rsp_last, rsp_err, m_axi_arvalid,
                                   m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 64'd0);
        check("rst_mid_data", {rsp_data, m_axi_araddr}, 64'd0);
        exp_q.delete(); ar_exp.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        gnt_log.delete();
        exp_read(1'b0, 32'h90, 1'b0);
        exp_read(1'b1, 32'hA0, 1'b0);
        fork
            request(0, 1'b0, 32'h94);
            request(1, 1'b0, 32'hA8);
        join
        wait_done();
        check_gnt("gnt_after_reset", 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
Shares the single AXI4 memory master port between the instruction-cache and data-cache line engines of the Kuuga core.
- Requester 0 is the I-cache: read fills only.
- Requester 1 is the D-cache: read fills and writeback.
- Arbitration is round-robin. Each granted request becomes exactly one INCR line burst of LINE_WORDS beats.
- Beats are streamed between the AXI port and the granted requester.
- The wrapper ties the constant AXI fields: axsize = log2(DATA_W/8), axburst = INCR, wstrb = all ones, axid = 0.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; one beat per word
LINE_WORDS, 4, words per cache line and beats per burst; power of two, 2..16

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  2  per-requester request; held high until req_ready
req_ready  out  2  one-cycle grant/accept pulse
req_we  in  2  1 = line write (bit 0 is ignored and treated as read)
req_addr  in  2*ADDR_W  request address; slice i belongs to requester i
wr_data  in  2*DATA_W  write beat data per requester
wr_valid  in  2  write beat valid
wr_ready  out  2  write beat accept
rsp_data  out  DATA_W  read beat data, shared
rsp_valid  out  2  response beat for requester i; no backpressure
rsp_last  out  1  final response of the transaction
rsp_err  out  1  error flag, valid with rsp_last
m_axi_araddr  out  ADDR_W  read address
m_axi_arlen  out  8  read burst length
m_axi_arvalid  out  1  read address valid
m_axi_arready  in  1  read address ready
m_axi_rdata  in  DATA_W  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  read last beat
m_axi_rvalid  in  1  read data valid
m_axi_rready  out  1  read data ready
m_axi_awaddr  out  ADDR_W  write address
m_axi_awlen  out  8  write burst length
m_axi_awvalid  out  1  write address valid
m_axi_awready  in  1  write address ready
m_axi_wdata  out  DATA_W  write data
m_axi_wlast  out  1  write last beat
m_axi_wvalid  out  1  write data valid
m_axi_wready  in  1  write data ready
m_axi_bresp  in  2  write response
m_axi_bvalid  in  1  write response valid
m_axi_bready  out  1  write response ready

Behaviour:
Reset
- Asynchronous. All valid, ready and last outputs go to 0. Data and address outputs go to 0.
- State returns to IDLE and the priority pointer returns to 0.
- Asserting reset mid-burst abandons the burst with no response. The AXI slave shares rst_n.

State machine
- States: IDLE, AR, RD, AW_W, B.
- IDLE: if any req_valid is high, grant the requester at the pointer if it is requesting, else the other one.
  - Drive req_ready[g]=1 for one cycle and capture the address, we and g.
  - Set pointer = ~g.
  - No grant is issued in any state other than IDLE.
- Address alignment: araddr/awaddr = req_addr & ~(LINE_WORDS*DATA_W/8 - 1). arlen = awlen = LINE_WORDS-1.
- AR: arvalid is registered high the cycle after the grant. arvalid and araddr stay stable until arready; then go to RD.
- RD: rready=1.
  - Each rvalid beat produces rsp_valid[g]=1 in the same cycle with rsp_data=rdata (combinational pass-through).
  - The beat counter increments per beat.
  - rsp_last=1 on beat LINE_WORDS-1, then go to IDLE.
  - If m_axi_rlast disagrees with the counter on any beat, rsp_err is set. The counter alone ends the burst.
- AW_W: awvalid is asserted on entry and dropped after awready. W beats run independently of AW.
  - wvalid = wr_valid[g], wdata = wr_data[g], wr_ready[g] = wready (combinational).
  - wlast=1 only when counter == LINE_WORDS-1.
  - Go to B once both the AW handshake and the last W handshake are done, in either order.
- B: bready=1. When bvalid arrives, emit rsp_valid[g]=1 with rsp_last=1 for one cycle, then go to IDLE.
- Errors: rsp_err accumulates any rresp/bresp != 2'b00 across the transaction. It is meaningful only with rsp_last and clears on the next grant.
- Back-to-back: one IDLE cycle is required between transactions. A losing requester keeps req_valid and wins the next IDLE arbitration.
- Outputs to the non-granted requester (req_ready, wr_ready, rsp_valid) stay 0 throughout.

Test Plan:
1. Reset low for 5 cycles -> every valid/ready/last output is 0. After release, I-cache read at 0x84 -> araddr 0x80, arlen 3; 4 rsp beats carry mem[32..35] (0x2400006f, 0x27c0006f, 34, 35); rsp_last on the 4th beat; rsp_err 0.
2. Both requesters raise req_valid in the same cycle with pointer 0 -> I-cache granted first; D-cache granted in the next IDLE. A repeated simultaneous request is then granted to the D-cache first.
3. D-cache write to 0x204 with data 0x11, 0x22, 0x33, 0x44 and wready toggling each cycle -> awaddr 0x200, awlen 3; data in order; wlast only on 0x44; a single rsp_valid[1] with rsp_last after bvalid.
4. arready held low for 10 cycles -> arvalid and araddr held stable, no rsp_valid, and no new grant to a pending D-cache request.
5. bresp=2'b10 -> rsp_err=1 with rsp_last. rresp=2'b10 on beat 1 only -> rsp_err=1 on beat 3 and clear on the next grant. rlast early on beat 2 -> rsp_err=1.
6. rst_n asserted after 2 of 4 read beats -> outputs 0 within the same cycle. After release, state is IDLE, pointer is 0, and a new request is served normally.
